// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect controller
// Merges stage stall requests with branch/exception redirects; holds a redirect until the fetch bus is idle.
module pipe_ctrl #(
   parameter int STALL_LIMIT = 1024,
   parameter int CNT_W       = 11
) (
   input  logic        clk_i,
   input  logic        n_rst_i,
   input  logic        stallreq_if_i,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic        stallreq_mem_i,
   input  logic        branch_i,
   input  logic [31:0] branch_pc_i,
   input  logic        exception_i,
   input  logic [31:0] exception_pc_i,
   input  logic        ifu_busy_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic        bflush_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        kill_fetch_o,
   output logic        stall_timeout_o
);
   typedef enum logic {RUN, PEND} state_t;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_tgt, w_tgt_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_timeout;
   logic [5:0]       w_req, w_stall;
   logic             w_flush, w_bflush, w_redirect, w_kill;
   logic [31:0]      w_redirect_pc;

   always_comb begin
      if (stallreq_mem_i)     w_req = 6'b011111;
      else if (stallreq_ex_i) w_req = 6'b001111;
      else if (stallreq_id_i) w_req = 6'b000111;
      else if (stallreq_if_i) w_req = 6'b000011;
      else                    w_req = 6'b000000;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_tgt_nxt     = r_tgt;
      w_stall       = w_req;
      w_flush       = 1'b0;
      w_bflush      = 1'b0;
      w_redirect    = 1'b0;
      w_redirect_pc = 32'h0;
      w_kill        = 1'b0;
      if (r_state == RUN) begin
         if (exception_i || branch_i) begin
            w_flush  = exception_i;
            w_bflush = !exception_i;
            w_stall  = 6'b000000;
            if (!ifu_busy_i) begin
               w_redirect    = 1'b1;
               w_redirect_pc = exception_i ? exception_pc_i : branch_pc_i;
            end else begin
               w_tgt_nxt   = exception_i ? exception_pc_i : branch_pc_i;
               w_state_nxt = PEND;
            end
         end
      end else begin
         // PC and IF held while the outstanding fetch drains; its response is discarded
         w_kill  = 1'b1;
         w_stall = w_req | 6'b000011;
         if (exception_i) begin
            w_flush   = 1'b1;
            w_tgt_nxt = exception_pc_i;
         end
         if (!ifu_busy_i) begin
            w_redirect    = 1'b1;
            w_redirect_pc = exception_i ? exception_pc_i : r_tgt;
            w_state_nxt   = RUN;
            w_stall       = w_req;
         end
         if (exception_i) w_stall = 6'b000000;
      end
   end

   assign w_cnt_nxt = !w_stall[0]     ? '0 :
                      (r_cnt == LIMIT) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         r_state   <= RUN;
         r_tgt     <= 32'h0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tgt   <= w_tgt_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_cnt_nxt == LIMIT) r_timeout <= 1'b1;
      end
   end

   assign stall_o         = n_rst_i ? w_stall       : 6'b000000;
   assign flush_o         = n_rst_i & w_flush;
   assign bflush_o        = n_rst_i & w_bflush;
   assign redirect_o      = n_rst_i & w_redirect;
   assign redirect_pc_o   = n_rst_i ? w_redirect_pc : 32'h0;
   assign kill_fetch_o    = n_rst_i & w_kill;
   assign stall_timeout_o = r_timeout;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
// Directed vector table, hand sequences for watchdog/reset, then randomized traffic against a reference model.
module tb_pipe_ctrl;
   localparam int LIMIT = 8;

   logic        clk_i = 1'b0;
   logic        n_rst_i;
   logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
   logic        branch_i, exception_i, ifu_busy_i;
   logic [31:0] branch_pc_i, exception_pc_i;
   logic [5:0]  stall_o;
   logic        flush_o, bflush_o, redirect_o, kill_fetch_o, stall_timeout_o;
   logic [31:0] redirect_pc_o;
   logic [42:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  req;   // {mem, ex, id, if}
      logic        br;
      logic [31:0] bpc;
      logic        ex;
      logic [31:0] epc;
      logic        busy;
      logic [42:0] exp;
   } vec_t;

   vec_t tbl[21];

   logic        m_pend;
   logic [31:0] m_tgt;
   int          m_run;
   logic        m_to;

   always #5 clk_i = ~clk_i;

   pipe_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(4)) dut (
      .clk_i(clk_i), .n_rst_i(n_rst_i),
      .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
      .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
      .branch_i(branch_i), .branch_pc_i(branch_pc_i),
      .exception_i(exception_i), .exception_pc_i(exception_pc_i),
      .ifu_busy_i(ifu_busy_i),
      .stall_o(stall_o), .flush_o(flush_o), .bflush_o(bflush_o),
      .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
      .kill_fetch_o(kill_fetch_o), .stall_timeout_o(stall_timeout_o)
   );

   assign obs = {stall_o, flush_o, bflush_o, redirect_o, redirect_pc_o, kill_fetch_o, stall_timeout_o};

   function automatic logic [42:0] mk(logic [5:0] s, logic f, logic b, logic r,
                                      logic [31:0] pc, logic k, logic t);
      return {s, f, b, r, pc, k, t};
   endfunction

   function automatic vec_t mkv(logic [3:0] req, logic br, logic [31:0] bpc, logic ex,
                                logic [31:0] epc, logic busy, logic [42:0] exp);
      vec_t v;
      v.req = req; v.br = br; v.bpc = bpc; v.ex = ex; v.epc = epc; v.busy = busy; v.exp = exp;
      return v;
   endfunction

   // highest requesting stage k (if=0..mem=3) holds stages 0..k+1
   function automatic logic [5:0] pattern(logic [3:0] req);
      for (int k = 3; k >= 0; k--)
         if (req[k]) return (6'd1 << (k + 2)) - 6'd1;
      return 6'd0;
   endfunction

   task automatic drive(input vec_t v);
      {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = v.req;
      branch_i = v.br; branch_pc_i = v.bpc;
      exception_i = v.ex; exception_pc_i = v.epc;
      ifu_busy_i = v.busy;
   endtask

   task automatic step(input string name, input logic [42:0] exp);
      @(negedge clk_i);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, obs, exp);
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic model(input logic rst, input vec_t v, output logic [42:0] e);
      logic [5:0]  s;
      logic        f, b, r, k;
      logic [31:0] pc;
      if (rst) begin
         m_pend = 1'b0; m_tgt = 32'h0; m_run = 0; m_to = 1'b0;
         e = '0;
         return;
      end
      s = pattern(v.req); f = 1'b0; b = 1'b0; r = 1'b0; k = 1'b0; pc = 32'h0;
      if (!m_pend) begin
         if (v.ex || v.br) begin
            f = v.ex; b = !v.ex; s = 6'd0;
            if (!v.busy) begin r = 1'b1; pc = v.ex ? v.epc : v.bpc; end
            else begin m_pend = 1'b1; m_tgt = v.ex ? v.epc : v.bpc; end
         end
      end else begin
         k = 1'b1;
         if (v.ex) m_tgt = v.epc;
         if (!v.busy) begin r = 1'b1; pc = m_tgt; m_pend = 1'b0; end
         else s = s | 6'b000011;
         if (v.ex) begin f = 1'b1; s = 6'd0; end
      end
      e = mk(s, f, b, r, pc, k, m_to);
      m_run = s[0] ? m_run + 1 : 0;
      if (m_run >= LIMIT) m_to = 1'b1;
   endtask

   initial begin
      vec_t        idle, v;
      logic [42:0] e;
      logic        rst;

      idle = mkv(4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, '0);
      tbl[0]  = mkv(4'b0010, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0, mk(6'h07, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = idle;
      tbl[4]  = mkv(4'b1001, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0, mk(6'h1F, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
      tbl[5]  = mkv(4'h0,    1'b1, 32'h100, 1'b0, 32'h0,         1'b0, mk(6'h00, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0));
      tbl[6]  = mkv(4'h0,    1'b0, 32'h0,   1'b1, 32'h8000_0000, 1'b1, mk(6'h00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
      tbl[7]  = mkv(4'h0,    1'b0, 32'h0,   1'b0, 32'h0,         1'b1, mk(6'h03, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
      tbl[8]  = tbl[7];
      tbl[9]  = mkv(4'h0,    1'b0, 32'h0,   1'b0, 32'h0,         1'b0, mk(6'h00, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0));
      tbl[10] = mkv(4'h0,    1'b1, 32'h100, 1'b0, 32'h0,         1'b1, mk(6'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
      tbl[11] = mkv(4'h0,    1'b0, 32'h0,   1'b1, 32'h200,       1'b1, mk(6'h00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
      tbl[12] = mkv(4'h0,    1'b1, 32'h300, 1'b0, 32'h0,         1'b1, mk(6'h03, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
      tbl[13] = mkv(4'h0,    1'b0, 32'h0,   1'b0, 32'h0,         1'b0, mk(6'h00, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0));
      tbl[14] = tbl[10];
      tbl[15] = mkv(4'b0010, 1'b1, 32'h300, 1'b0, 32'h0,         1'b1, mk(6'h07, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0));
      tbl[16] = mkv(4'b0010, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0, mk(6'h07, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0));
      tbl[17] = idle;
      tbl[18] = mkv(4'h0,    1'b1, 32'h40,  1'b0, 32'h0,         1'b1, mk(6'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
      tbl[19] = mkv(4'h0,    1'b0, 32'h0,   1'b1, 32'h500,       1'b0, mk(6'h00, 1'b1, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0));
      tbl[20] = idle;

      // reset holds every output low even with live requests
      n_rst_i = 1'b0;
      drive(mkv(4'b1001, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, '0));
      @(posedge clk_i); #1;
      step("reset_outputs", '0);
      step("reset_outputs2", '0);
      n_rst_i = 1'b1;

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i]);
         step($sformatf("vec%0d", i), tbl[i].exp);
      end

      // reset asserted mid-PEND drops the pending redirect
      drive(mkv(4'h0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1, '0));
      step("pend_enter", mk(6'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
      n_rst_i = 1'b0;
      drive(idle);
      step("pend_reset", '0);
      n_rst_i = 1'b1;
      step("pend_dropped", '0);

      // watchdog: continuous stall from cycle 0 sets the flag from cycle LIMIT
      n_rst_i = 1'b0; step("wd_reset", '0); n_rst_i = 1'b1;
      drive(mkv(4'b1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, '0));
      for (int c = 0; c <= LIMIT; c++)
         step($sformatf("wd_cycle%0d", c), mk(6'h1F, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, c >= LIMIT));
      drive(idle);
      for (int c = 0; c < 3; c++)
         step($sformatf("wd_sticky%0d", c), mk(6'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1));
      n_rst_i = 1'b0;
      step("wd_cleared", '0);
      n_rst_i = 1'b1;
      step("wd_after_reset", '0);

      // randomized traffic against the reference model
      m_pend = 1'b0; m_tgt = 32'h0; m_run = 0; m_to = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         v.req  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         v.br   = ($urandom_range(0, 5) == 0);
         v.bpc  = $urandom;
         v.ex   = ($urandom_range(0, 7) == 0);
         v.epc  = $urandom;
         v.busy = ($urandom_range(0, 9) < 6);
         rst    = ($urandom_range(0, 99) == 0);
         n_rst_i = !rst;
         drive(v);
         model(rst, v, e);
         step($sformatf("rand%0d", i), e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit: the producer of the stall vector and flush signals consumed by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It merges per-stage stall requests, branch-mispredict and exception redirects into one stall/flush decision per cycle. A redirect that arrives while an instruction fetch is still outstanding is held until the fetch bus goes idle. A watchdog flags a pipeline frozen for too long.

## Interface
- STALL_LIMIT, 1024: consecutive cycles with stall_o[0]=1 before stall_timeout_o sets.
- CNT_W, 11: width of the watchdog counter; must satisfy 2^CNT_W > STALL_LIMIT.
- clk_i  in  1  clock; all state updates on the rising edge.
- n_rst_i  in  1  reset; asynchronous, active-low.
- stallreq_if_i  in  1  fetch stage requests a stall.
- stallreq_id_i  in  1  decode stage requests a stall (load-use).
- stallreq_ex_i  in  1  execute stage requests a stall (multi-cycle op).
- stallreq_mem_i  in  1  memory stage requests a stall (data bus wait).
- branch_i  in  1  EX resolved a mispredict; redirect to branch_pc_i.
- branch_pc_i  in  32  branch redirect target.
- exception_i  in  1  trap or return taken in MEM; redirect to exception_pc_i.
- exception_pc_i  in  32  trap vector or return address.
- ifu_busy_i  in  1  instruction fetch request outstanding on the bus.
- stall_o  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- flush_o  out  1  exception flush of all inter-stage registers.
- bflush_o  out  1  branch flush of IF/ID and ID/EX only.
- redirect_o  out  1  load redirect_pc_o into the PC this cycle.
- redirect_pc_o  out  32  redirect target.
- kill_fetch_o  out  1  discard the fetch response returning this cycle.
- stall_timeout_o  out  1  sticky watchdog flag.

## Operation
- State register: RUN or PEND. Target register tgt, 32 bits.
- Request stall pattern, highest priority wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
- RUN:
  - exception_i: flush_o=1 and stall_o=0.
    - If ifu_busy_i=0: redirect_o=1 and redirect_pc_o=exception_pc_i.
    - Otherwise: tgt<=exception_pc_i, go to PEND, redirect_o=0.
  - else branch_i: bflush_o=1, stall_o=0, same redirect/PEND rule using branch_pc_i.
  - else: stall_o = request pattern.
- PEND:
  - stall_o = request pattern | 6'b000011; kill_fetch_o=1.
  - exception_i: flush_o=1 and tgt<=exception_pc_i; the exception overrides the pending target.
  - branch_i is ignored.
  - When ifu_busy_i=0: redirect_o=1, redirect_pc_o = exception_pc_i if exception_i is asserted in that cycle, else tgt. Return to RUN; stall_o bits 1:0 revert to the request pattern in that same cycle.
- Outputs are combinational from state and inputs. redirect_pc_o=0 when redirect_o=0. flush_o and bflush_o are never asserted together.
- Watchdog:
  - cnt increments while stall_o[0]=1, saturating at STALL_LIMIT, and clears when stall_o[0]=0.
  - stall_timeout_o<=1 when cnt reaches STALL_LIMIT; it clears only on reset.

## Timing
- Reset, asynchronous, while n_rst_i=0:
  - state=RUN, tgt=0, cnt=0, stall_timeout_o=0.
  - All other outputs forced to 0 regardless of inputs.
- Zero-latency paths: stall, flush and redirect assert in the same cycle as the request and take effect at the next clock edge in the consumers.
- A flush cycle asserts stall_o=0, so the ID/EX bubble rule (stall[2]=1, stall[3]=0) never fires in that cycle.
- PEND entry to exit is at least 1 cycle; the exit cycle is the first cycle with ifu_busy_i=0.
- Reset asserted mid-PEND: the pending redirect is dropped and the block returns to RUN.
- Watchdog: with continuous stall starting at cycle 0, stall_timeout_o is visible from cycle STALL_LIMIT onward.

## Test plan
- Reset, then stallreq_id_i=1 for 3 cycles -> stall_o=6'b000111 for 3 cycles, then 6'b000000; no flush.
- stallreq_if_i=1 and stallreq_mem_i=1 together -> stall_o=6'b011111.
- branch_i=1, branch_pc_i=32'h0000_0100, ifu_busy_i=0 -> in the same cycle bflush_o=1, redirect_o=1, redirect_pc_o=32'h100, stall_o=0.
- exception_i=1, exception_pc_i=32'h8000_0000, ifu_busy_i=1 for 3 cycles:
  - flush_o=1 in cycle 0 only.
  - stall_o=6'b000011 and kill_fetch_o=1 in cycles 1–2.
  - In cycle 3 (busy drops): redirect_o=1, redirect_pc_o=32'h8000_0000, kill_fetch_o=1, stall_o=0.
- While in PEND with tgt=32'h100:
  - exception_i with exception_pc_i=32'h200 -> flush_o=1 and the later redirect uses 32'h200.
  - branch_i in PEND -> no bflush_o and tgt unchanged.
- STALL_LIMIT=8, stallreq_mem_i held high -> stall_timeout_o=1 from cycle 8; it stays 1 after the stall is released, and clears only on n_rst_i=0.
